// File: rtl/als_controlador_sequenciador.sv
// ---------------------------------------------------------------------------
// als_controlador_sequenciador
//
// Controller/sequencer for a SAP-1 style processor. A six-state ring counter
// (T1..T6) walks through fetch (T1-T3) and execute (T4-T6). The 12-bit control
// word is a combinational decode of the registered T-state and the opcode.
// In free-run the ring advances on every clock; in manual mode it advances
// once per synchronized rising edge of the step pushbutton. HLT freezes the
// ring in T4 until clr.
//
// Ports
//   clk     in   1  single clock, all state on rising edge
//   clr     in   1  asynchronous active-high reset, restarts at T1
//   opcode  in   4  instruction register upper nibble, valid from T4
//   manual  in   1  1 = single-step, 0 = free-run
//   step    in   1  manual step pushbutton, asynchronous to clk
//   con     out 12  {Cp,Ep,nLm,nCe,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}
//   t       out  6  one-hot T-state (bit 0 = T1 .. bit 5 = T6); also the
//                   FSM state for observation
//   hlt     out  1  high while halted
//
// There is no valid/ready handshake: every output is meaningful on every
// cycle and reflects the registered state decoded combinationally.
// ---------------------------------------------------------------------------
module als_controlador_sequenciador (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  opcode,
  input  logic        manual,
  input  logic        step,
  output logic [11:0] con,
  output logic [5:0]  t,
  output logic        hlt
);

  // One-hot encoding so the state register itself is the t output.
  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  localparam logic [3:0]  OP_LDA = 4'b0000;
  localparam logic [3:0]  OP_ADD = 4'b0001;
  localparam logic [3:0]  OP_SUB = 4'b0010;
  localparam logic [3:0]  OP_OUT = 4'b1110;
  localparam logic [3:0]  OP_HLT = 4'b1111;
  localparam logic [11:0] CON_IDLE = 12'h3E3;

  t_state_e state_q, state_d;
  logic     hlt_q, hlt_d;
  logic     step_s1, step_s2, step_s3;
  logic     step_rise;
  logic     advance;

  // Two-flop synchronizer followed by an edge register. It keeps running
  // regardless of manual so that entering manual mode with step already
  // held high does not produce a spurious advance.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_s3 <= 1'b0;
    end else begin
      step_s1 <= step;
      step_s2 <= step_s1;
      step_s3 <= step_s2;
    end
  end

  assign step_rise = step_s2 & ~step_s3;
  assign advance   = ~hlt_q & (manual ? step_rise : 1'b1);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= T1;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hlt_q   <= hlt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hlt_d   = hlt_q;
    if (advance) begin
      case (state_q)
        T1: state_d = T2;
        T2: state_d = T3;
        T3: begin
          // HLT still lands in T4, then the ring freezes there.
          state_d = T4;
          if (opcode == OP_HLT) hlt_d = 1'b1;
        end
        T4: state_d = T5;
        T5: state_d = T6;
        T6: state_d = T1;
        default: state_d = T1;
      endcase
    end
  end

  always_comb begin
    con = CON_IDLE;
    if (!hlt_q) begin
      case (state_q)
        T1: con = 12'h5E3;
        T2: con = 12'hBE3;
        T3: con = 12'h263;
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: con = 12'h1A3;
            OP_OUT:                 con = 12'h3F2;
            default:                con = CON_IDLE;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA:         con = 12'h2C3;
            OP_ADD, OP_SUB: con = 12'h2E1;
            default:        con = CON_IDLE;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD:  con = 12'h3C7;
            OP_SUB:  con = 12'h3CF;
            default: con = CON_IDLE;
          endcase
        end
        default: con = CON_IDLE;
      endcase
    end
  end

  assign t   = state_q;
  assign hlt = hlt_q;

endmodule

// File: tb/tb_als_controlador_sequenciador.sv
// ---------------------------------------------------------------------------
// Bench for als_controlador_sequenciador. A behavioural model (integer
// T-index, halted flag, history of sampled step values) predicts {hlt,t,con}
// after every rising edge; the prediction is queued and a monitor compares it
// against the DUT on the following falling edge. Asynchronous clr effects are
// checked directly between edges.
// ---------------------------------------------------------------------------
module tb_als_controlador_sequenciador;

  logic        clk;
  logic        clr;
  logic [3:0]  opcode;
  logic        manual;
  logic        step;
  logic [11:0] con;
  logic [5:0]  t;
  logic        hlt;

  int checks   = 0;
  int failures = 0;

  logic [18:0] exp_q[$];

  // Reference model state
  int   m_ts;        // 0 = T1 .. 5 = T6
  bit   m_halted;
  bit   m_hist[3];   // step sampled at the last three edges, [0] newest

  als_controlador_sequenciador dut (
    .clk    (clk),
    .clr    (clr),
    .opcode (opcode),
    .manual (manual),
    .step   (step),
    .con    (con),
    .t      (t),
    .hlt    (hlt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [11:0] con_ref(int ts, logic [3:0] op, bit halted);
    logic [11:0] r;
    r = 12'h3E3;
    if (halted) return 12'h3E3;
    case (ts)
      0: r = 12'h5E3;
      1: r = 12'hBE3;
      2: r = 12'h263;
      3: if (op == 4'h0 || op == 4'h1 || op == 4'h2) r = 12'h1A3;
         else if (op == 4'hE) r = 12'h3F2;
      4: if (op == 4'h0) r = 12'h2C3;
         else if (op == 4'h1 || op == 4'h2) r = 12'h2E1;
      5: if (op == 4'h1) r = 12'h3C7;
         else if (op == 4'h2) r = 12'h3CF;
      default: r = 12'h3E3;
    endcase
    return r;
  endfunction

  function automatic logic [18:0] expected_now();
    logic [5:0] oh;
    oh = 6'b000001 << m_ts;
    return {m_halted, oh, con_ref(m_ts, opcode, m_halted)};
  endfunction

  // Rising edge: a step rise is recognised when step was high two edges ago
  // and low three edges ago (two sync stages plus one edge register).
  task automatic model_edge();
    bit adv;
    if (clr) begin
      m_ts = 0;
      m_halted = 0;
      m_hist = '{0, 0, 0};
      return;
    end
    adv = manual ? (m_hist[1] && !m_hist[2]) : 1'b1;
    if (!m_halted && adv) begin
      if (m_ts == 2 && opcode == 4'hF) begin
        m_ts = 3;
        m_halted = 1;
      end else begin
        m_ts = (m_ts + 1) % 6;
      end
    end
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = step;
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; inputs are already set by the caller.
  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    exp_q.push_back(expected_now());
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic direct_check(string name, logic [18:0] want);
    checks++;
    if ({hlt, t, con} !== want) begin
      failures++;
      $display("FAIL %s: got hlt=%0b t=%06b con=%03h, want hlt=%0b t=%06b con=%03h",
               name, hlt, t, con, want[18], want[17:12], want[11:0]);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [18:0] e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({hlt, t, con} !== e) begin
          failures++;
          $display("FAIL cycle@%0t: got hlt=%0b t=%06b con=%03h, want hlt=%0b t=%06b con=%03h",
                   $time, hlt, t, con, e[18], e[17:12], e[11:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    logic [3:0] ops[6];
    ops = '{4'h0, 4'h1, 4'h2, 4'hE, 4'h7, 4'h5};

    clr = 1'b1; opcode = 4'h0; manual = 1'b0; step = 1'b0;
    m_ts = 0; m_halted = 0; m_hist = '{0, 0, 0};
    @(negedge clk);
    #1;
    direct_check("reset_state", {1'b0, 6'b000001, 12'h5E3});
    ticks(3);  // clr held: no advance

    // Free-run LDA sequence
    clr = 1'b0;
    ticks(12);

    // SUB then ADD
    opcode = 4'h2; ticks(6);
    opcode = 4'h1; ticks(6);

    // Random non-HLT opcodes, changing on any cycle
    for (int i = 0; i < 60; i++) begin
      opcode = ops[$urandom_range(0, 5)];
      tick();
    end

    // HLT: reach T4 and stay frozen for 20+ clocks
    guard = 0;
    opcode = 4'h0;
    while (m_ts != 0 && guard < 10) begin tick(); guard++; end
    opcode = 4'hF;
    ticks(25);
    step = 1'b1; manual = 1'b1; ticks(4); step = 1'b0; manual = 1'b0; ticks(2);
    clr = 1'b1;
    #1;
    direct_check("clr_while_halted", {1'b0, 6'b000001, 12'h5E3});
    tick();
    clr = 1'b0; opcode = 4'h0;
    ticks(3);

    // Manual mode: restart cleanly from T1
    clr = 1'b1; tick(); clr = 1'b0;
    manual = 1'b1; step = 1'b0;
    ticks(10);
    step = 1'b1; ticks(8);
    step = 1'b0; ticks(4);
    step = 1'b1; ticks(1);
    step = 1'b0; ticks(5);
    for (int i = 0; i < 40; i++) begin
      opcode = ops[$urandom_range(0, 5)];
      step = ($urandom_range(0, 3) == 0);
      tick();
    end

    // Toggling manual mid-instruction
    for (int i = 0; i < 40; i++) begin
      manual = ($urandom_range(0, 1) == 1);
      step = ($urandom_range(0, 2) == 0);
      opcode = ops[$urandom_range(0, 5)];
      tick();
    end

    // HLT reached in manual mode
    manual = 1'b0; step = 1'b0; opcode = 4'h0;
    clr = 1'b1; tick(); clr = 1'b0;
    ticks(2);
    manual = 1'b1; opcode = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; ticks(2); step = 1'b0; ticks(3);
    end
    ticks(5);

    // Async clr during T5, then undefined opcode round trip
    manual = 1'b0; step = 1'b0; opcode = 4'h0;
    clr = 1'b1; tick(); clr = 1'b0;
    guard = 0;
    while (m_ts != 4 && guard < 10) begin tick(); guard++; end
    checks++;
    if (m_ts != 4 || t !== 6'b010000) begin
      failures++;
      $display("FAIL reach_t5: got t=%06b, want t=010000", t);
    end
    clr = 1'b1;
    #1;
    direct_check("async_clr_t5", {1'b0, 6'b000001, 12'h5E3});
    tick();
    clr = 1'b0; opcode = 4'h7;
    ticks(8);

    ticks(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
